// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
//   MODE_MEALY / MODE_REG : values for the MEALY parameter of seq_detector_prog
//   len_w()               : bit width needed to hold a length 0..max_len
package seq_det_pkg;

  localparam int unsigned MODE_REG   = 0;
  localparam int unsigned MODE_MEALY = 1;

  // Width of a field that must represent every value 0..max_len inclusive.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   reset : synchronous active-high reset, counter -> 0
//   clr   : synchronous clear, wins over inc
//   inc   : add one unless already at all-ones
//   cnt   : registered count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear first, otherwise increment until saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector.
//   clk, reset : clock and synchronous active-high reset
//   seq        : serial data bit, sampled when seq_valid is high
//   seq_valid  : qualifies seq
//   overlap    : 1 = overlapping matches, 0 = a match restarts the fill count
//   pat_load   : load pat_in / len_in (clamped to MAX_LEN); seq ignored that cycle
//   pat_in     : pattern, bit [len-1] oldest, bit [0] newest
//   len_in     : pattern length; 0 disables detection
//   cnt_clr    : clear the match counter (wins over a same-cycle match)
//   detected   : match pulse, same cycle (MEALY=1) or one cycle later (MEALY=0)
//   match_cnt  : saturating number of matches
//   busy_fill  : number of valid history bits, saturates at MAX_LEN
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned         MAX_LEN  = 8,
  parameter int unsigned         CNT_W    = 8,
  parameter int unsigned         MEALY    = MODE_MEALY,
  parameter logic [MAX_LEN-1:0]  PAT_INIT = MAX_LEN'(8'b0000_1011),
  parameter int unsigned         LEN_INIT = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           seq,
  input  logic                           seq_valid,
  input  logic                           overlap,
  input  logic                           pat_load,
  input  logic [MAX_LEN-1:0]             pat_in,
  input  logic [$clog2(MAX_LEN+1)-1:0]   len_in,
  input  logic                           cnt_clr,
  output logic                           detected,
  output logic [CNT_W-1:0]               match_cnt,
  output logic [$clog2(MAX_LEN+1)-1:0]   busy_fill
);

  localparam int unsigned LW = len_w(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q,  pat_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic [LW-1:0]      len_q,  len_d;
  logic               det_q;

  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] len_mask;
  logic [LW-1:0]      fill_inc;
  logic               match_c;

  // Post-shift view of the history, compare mask and next-state logic.
  always_comb begin
    hist_shift = {hist_q[MAX_LEN-2:0], seq};
    fill_inc   = (fill_q >= LW'(MAX_LEN)) ? LW'(MAX_LEN) : fill_q + LW'(1);

    // Only the newest len bits take part in the compare.
    len_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < 32'(len_q));
    end

    // A load cycle ignores seq entirely, so it can never produce a match.
    match_c = seq_valid && !pat_load && !reset && (len_q != '0) &&
              (fill_inc >= len_q) &&
              (((hist_shift ^ pat_q) & len_mask) == '0);

    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    if (pat_load) begin
      pat_d  = pat_in;
      len_d  = (len_in > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len_in;
      fill_d = '0;
    end else if (seq_valid) begin
      hist_d = hist_shift;
      // Non-overlapping mode needs len fresh bits before the next match.
      fill_d = (match_c && !overlap) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PAT_INIT;
      len_q  <= LW'(LEN_INIT);
      det_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      det_q  <= match_c;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (match_c),
    .cnt   (match_cnt)
  );

  assign detected  = (MEALY == MODE_MEALY) ? match_c : det_q;
  assign busy_fill = fill_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
module tb_seq_detector_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, seq, seq_valid, overlap, pat_load, cnt_clr;
  logic [7:0] pat_in;
  logic [3:0] len_in;

  logic       det_a, det_b, det_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [3:0] fill_a, fill_b, fill_c;

  // Mealy, default counter
  seq_detector_prog #(.MEALY(1)) dut_m (
    .clk(clk), .reset(reset), .seq(seq), .seq_valid(seq_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in), .cnt_clr(cnt_clr),
    .detected(det_a), .match_cnt(cnt_a), .busy_fill(fill_a));

  // Registered output
  seq_detector_prog #(.MEALY(0)) dut_r (
    .clk(clk), .reset(reset), .seq(seq), .seq_valid(seq_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in), .cnt_clr(cnt_clr),
    .detected(det_b), .match_cnt(cnt_b), .busy_fill(fill_b));

  // Narrow counter for saturation
  seq_detector_prog #(.MEALY(1), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .seq(seq), .seq_valid(seq_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in), .cnt_clr(cnt_clr),
    .detected(det_c), .match_cnt(cnt_c), .busy_fill(fill_c));

  typedef struct {
    logic       det_m;
    logic       det_r;
    logic [7:0] cnt;
    logic [3:0] fill;
    logic [1:0] cnt2;
  } obs_t;

  typedef struct {
    logic       det;
    logic [7:0] cnt;
    logic [3:0] fill;
    logic [1:0] cnt2;
  } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // One clock: push the expectation, drive, sample Mealy before the edge
  // and registered outputs after it.
  task automatic cyc(input int s, input int v, input int ld, input int clr, input int rst,
                     input int d, input int c, input int f, input int c2);
    exp_t e;
    obs_t o;
    e.det  = 1'(d);
    e.cnt  = 8'(c);
    e.fill = 4'(f);
    e.cnt2 = 2'(c2);
    exp_q.push_back(e);
    @(negedge clk);
    seq       = 1'(s);
    seq_valid = 1'(v);
    pat_load  = 1'(ld);
    cnt_clr   = 1'(clr);
    reset     = 1'(rst);
    #1;
    o.det_m = det_a;
    @(posedge clk);
    #1;
    o.det_r = det_b;
    o.cnt   = cnt_a;
    o.fill  = fill_a;
    o.cnt2  = cnt_c;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    obs_t o;
    exp_t e;
    int   n = 0;
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 1, 0, 0, 0, 0);
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n++;
      checks += 5;
      if (o.det_m !== e.det)  begin failures++; $display("FAIL reset det_mealy cyc=%0d got=%b exp=%b", n, o.det_m, e.det); end
      if (o.det_r !== e.det)  begin failures++; $display("FAIL reset det_reg cyc=%0d got=%b exp=%b", n, o.det_r, e.det); end
      if (o.cnt   !== e.cnt)  begin failures++; $display("FAIL reset match_cnt cyc=%0d got=%0d exp=%0d", n, o.cnt, e.cnt); end
      if (o.fill  !== e.fill) begin failures++; $display("FAIL reset busy_fill cyc=%0d got=%0d exp=%0d", n, o.fill, e.fill); end
      if (o.cnt2  !== e.cnt2) begin failures++; $display("FAIL reset cnt2 cyc=%0d got=%0d exp=%0d", n, o.cnt2, e.cnt2); end
    end
  endtask

  task automatic test_overlap();
    int   s[7] = '{1, 0, 1, 1, 0, 1, 1};
    int   d[7] = '{0, 0, 0, 1, 0, 0, 1};
    int   c[7] = '{0, 0, 0, 1, 1, 1, 2};
    obs_t o;
    exp_t e;
    int   n = 0;
    overlap = 1'b1;
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(s[i], 1, 0, 0, 0, d[i], c[i], i + 1, c[i]);
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n++;
      checks += 5;
      if (o.det_m !== e.det)  begin failures++; $display("FAIL overlap det_mealy cyc=%0d got=%b exp=%b", n, o.det_m, e.det); end
      if (o.det_r !== e.det)  begin failures++; $display("FAIL overlap det_reg cyc=%0d got=%b exp=%b", n, o.det_r, e.det); end
      if (o.cnt   !== e.cnt)  begin failures++; $display("FAIL overlap match_cnt cyc=%0d got=%0d exp=%0d", n, o.cnt, e.cnt); end
      if (o.fill  !== e.fill) begin failures++; $display("FAIL overlap busy_fill cyc=%0d got=%0d exp=%0d", n, o.fill, e.fill); end
      if (o.cnt2  !== e.cnt2) begin failures++; $display("FAIL overlap cnt2 cyc=%0d got=%0d exp=%0d", n, o.cnt2, e.cnt2); end
    end
  endtask

  task automatic test_non_overlap();
    int   s[7] = '{1, 0, 1, 1, 0, 1, 1};
    int   d[7] = '{0, 0, 0, 1, 0, 0, 0};
    int   c[7] = '{0, 0, 0, 1, 1, 1, 1};
    int   f[7] = '{1, 2, 3, 0, 1, 2, 3};
    obs_t o;
    exp_t e;
    int   n = 0;
    overlap = 1'b0;
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(s[i], 1, 0, 0, 0, d[i], c[i], f[i], c[i]);
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n++;
      checks += 5;
      if (o.det_m !== e.det)  begin failures++; $display("FAIL nonoverlap det_mealy cyc=%0d got=%b exp=%b", n, o.det_m, e.det); end
      if (o.det_r !== e.det)  begin failures++; $display("FAIL nonoverlap det_reg cyc=%0d got=%b exp=%b", n, o.det_r, e.det); end
      if (o.cnt   !== e.cnt)  begin failures++; $display("FAIL nonoverlap match_cnt cyc=%0d got=%0d exp=%0d", n, o.cnt, e.cnt); end
      if (o.fill  !== e.fill) begin failures++; $display("FAIL nonoverlap busy_fill cyc=%0d got=%0d exp=%0d", n, o.fill, e.fill); end
      if (o.cnt2  !== e.cnt2) begin failures++; $display("FAIL nonoverlap cnt2 cyc=%0d got=%0d exp=%0d", n, o.cnt2, e.cnt2); end
    end
  endtask

  task automatic test_load();
    int   d1[5] = '{0, 0, 1, 1, 1};
    int   c1[5] = '{0, 0, 1, 2, 3};
    int   d2[5] = '{0, 0, 1, 0, 0};
    int   c2[5] = '{3, 3, 4, 4, 4};
    int   f2[5] = '{1, 2, 0, 1, 2};
    obs_t o;
    exp_t e;
    int   n = 0;
    pat_in  = 8'b0000_0111;
    len_in  = 4'd3;
    overlap = 1'b1;
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, d1[i], c1[i], i + 1, c1[i]);
    overlap = 1'b0;
    cyc(0, 0, 1, 0, 0, 0, 3, 0, 3);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, d2[i], c2[i], f2[i], 3);
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n++;
      checks += 5;
      if (o.det_m !== e.det)  begin failures++; $display("FAIL load det_mealy cyc=%0d got=%b exp=%b", n, o.det_m, e.det); end
      if (o.det_r !== e.det)  begin failures++; $display("FAIL load det_reg cyc=%0d got=%b exp=%b", n, o.det_r, e.det); end
      if (o.cnt   !== e.cnt)  begin failures++; $display("FAIL load match_cnt cyc=%0d got=%0d exp=%0d", n, o.cnt, e.cnt); end
      if (o.fill  !== e.fill) begin failures++; $display("FAIL load busy_fill cyc=%0d got=%0d exp=%0d", n, o.fill, e.fill); end
      if (o.cnt2  !== e.cnt2) begin failures++; $display("FAIL load cnt2 cyc=%0d got=%0d exp=%0d", n, o.cnt2, e.cnt2); end
    end
  endtask

  // Valid gaps with junk, mid-stream reload, mid-stream reset.
  task automatic test_gaps();
    // seq, valid, load, det, cnt, fill
    int   t[15][6] = '{
      '{1, 1, 0, 0, 0, 1}, '{1, 0, 0, 0, 0, 1}, '{0, 1, 0, 0, 0, 2},
      '{1, 0, 0, 0, 0, 2}, '{1, 1, 0, 0, 0, 3}, '{0, 0, 0, 0, 0, 3},
      '{1, 1, 0, 1, 1, 4}, '{1, 1, 0, 0, 1, 5}, '{0, 1, 0, 0, 1, 6},
      '{1, 1, 0, 0, 1, 7}, '{1, 1, 1, 0, 1, 0}, '{1, 1, 0, 0, 1, 1},
      '{0, 1, 0, 0, 1, 2}, '{1, 1, 0, 0, 1, 3}, '{1, 1, 0, 1, 2, 4}};
    obs_t o;
    exp_t e;
    int   n = 0;
    pat_in  = 8'b0000_1011;
    len_in  = 4'd4;
    overlap = 1'b1;
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++)
      cyc(t[i][0], t[i][1], t[i][2], 0, 0, t[i][3], t[i][4], t[i][5], t[i][4]);
    cyc(1, 1, 0, 0, 1, 0, 0, 0, 0);
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n++;
      checks += 5;
      if (o.det_m !== e.det)  begin failures++; $display("FAIL gaps det_mealy cyc=%0d got=%b exp=%b", n, o.det_m, e.det); end
      if (o.det_r !== e.det)  begin failures++; $display("FAIL gaps det_reg cyc=%0d got=%b exp=%b", n, o.det_r, e.det); end
      if (o.cnt   !== e.cnt)  begin failures++; $display("FAIL gaps match_cnt cyc=%0d got=%0d exp=%0d", n, o.cnt, e.cnt); end
      if (o.fill  !== e.fill) begin failures++; $display("FAIL gaps busy_fill cyc=%0d got=%0d exp=%0d", n, o.fill, e.fill); end
      if (o.cnt2  !== e.cnt2) begin failures++; $display("FAIL gaps cnt2 cyc=%0d got=%0d exp=%0d", n, o.cnt2, e.cnt2); end
    end
  endtask

  // Saturation, clear-vs-match, len 0 disable, fill saturation, len clamp.
  task automatic test_counter();
    int   c2a[5] = '{1, 2, 3, 3, 3};
    obs_t o;
    exp_t e;
    int   n = 0;
    int   c;
    pat_in  = 8'b0000_0001;
    len_in  = 4'd1;
    overlap = 1'b1;
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, 1, i + 1, i + 1, c2a[i]);
    cyc(1, 1, 0, 1, 0, 1, 0, 6, 0);
    cyc(1, 1, 0, 0, 0, 1, 1, 7, 1);
    len_in = 4'd0;
    cyc(0, 0, 1, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 0, 0, 0, 1, (i < 8) ? i + 1 : 8, 1);
    pat_in = 8'hFF;
    len_in = 4'd15;
    cyc(0, 0, 1, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 9; i++) begin
      c = (i < 7) ? 1 : (i == 7) ? 2 : 3;
      cyc(1, 1, 0, 0, 0, (i >= 7) ? 1 : 0, c, (i < 8) ? i + 1 : 8, c);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n++;
      checks += 5;
      if (o.det_m !== e.det)  begin failures++; $display("FAIL counter det_mealy cyc=%0d got=%b exp=%b", n, o.det_m, e.det); end
      if (o.det_r !== e.det)  begin failures++; $display("FAIL counter det_reg cyc=%0d got=%b exp=%b", n, o.det_r, e.det); end
      if (o.cnt   !== e.cnt)  begin failures++; $display("FAIL counter match_cnt cyc=%0d got=%0d exp=%0d", n, o.cnt, e.cnt); end
      if (o.fill  !== e.fill) begin failures++; $display("FAIL counter busy_fill cyc=%0d got=%0d exp=%0d", n, o.fill, e.fill); end
      if (o.cnt2  !== e.cnt2) begin failures++; $display("FAIL counter cnt2 cyc=%0d got=%0d exp=%0d", n, o.cnt2, e.cnt2); end
    end
  endtask

  initial begin
    reset     = 1'b1;
    seq       = 1'b0;
    seq_valid = 1'b0;
    overlap   = 1'b1;
    pat_load  = 1'b0;
    cnt_clr   = 1'b0;
    pat_in    = 8'b0000_1011;
    len_in    = 4'd4;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_load();
    test_gaps();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
